// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_addr_gen
// Description : Accepts one (height, width) anchor per window from the anchor
//               generator and emits the KxK feature-map read addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_addr_gen #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 32,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_WIDTH  = 16,
    parameter int ANCHOR_NUM  = 900
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  anchor_en,
    output logic                  anchor_pause,
    input  logic [31:0]           anchor_height,
    input  logic [31:0]           anchor_width,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_vld,
    input  logic                  addr_rdy,
    output logic                  win_last,
    output logic                  frame_done
);

    localparam int c_IDX_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int c_CNT_W  = $clog2(ANCHOR_NUM + 1);
    localparam int c_CALC_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

    localparam logic [c_IDX_W-1:0]    c_K_LAST      = c_IDX_W'(KERNEL_SIZE - 1);
    localparam logic [c_CNT_W-1:0]    c_ANCHOR_LAST = c_CNT_W'(ANCHOR_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_STEP    = ADDR_WIDTH'(IMG_WIDTH - KERNEL_SIZE + 1);
    localparam logic [c_CALC_W-1:0]   c_BASE        = c_CALC_W'(BASE_ADDR);
    localparam logic [c_CALC_W-1:0]   c_PITCH       = c_CALC_W'(IMG_WIDTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_WALK = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [1:0]            r_state,        w_state;
    logic                  r_anchor_en,    w_anchor_en;
    logic                  r_anchor_pause, w_anchor_pause;
    logic [ADDR_WIDTH-1:0] r_addr,         w_addr;
    logic                  r_addr_vld,     w_addr_vld;
    logic [c_IDX_W-1:0]    r_row,          w_row;
    logic [c_IDX_W-1:0]    r_col,          w_col;
    logic [c_CNT_W-1:0]    r_cnt,          w_cnt;
    logic [31:0]           r_h,            w_h;
    logic [31:0]           r_w,            w_w;

    logic                  w_accept;
    logic                  w_handshake;
    logic [c_CALC_W-1:0]   w_load_full;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic                  w_unused_calc;

    // Window origin; the only place the multiplier is used.
    assign w_load_full   = c_BASE + c_CALC_W'(r_h) * c_PITCH + c_CALC_W'(r_w);
    assign w_load_addr   = w_load_full[ADDR_WIDTH-1:0];
    assign w_unused_calc = ^w_load_full;

    assign w_accept    = (r_state == c_S_IDLE) && r_anchor_en && !r_anchor_pause;
    assign w_handshake = r_addr_vld && addr_rdy;

    always_comb begin
        w_state     = r_state;
        w_anchor_en = enable;
        w_addr      = r_addr;
        w_addr_vld  = r_addr_vld;
        w_row       = r_row;
        w_col       = r_col;
        w_cnt       = r_cnt;
        w_h         = r_h;
        w_w         = r_w;

        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_h     = anchor_height;
                    w_w     = anchor_width;
                    w_state = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                w_addr     = w_load_addr;
                w_row      = '0;
                w_col      = '0;
                w_addr_vld = 1'b1;
                w_state    = c_S_WALK;
            end
            c_S_WALK: begin
                if (w_handshake) begin
                    if (r_col != c_K_LAST) begin
                        w_col  = r_col + c_IDX_W'(1);
                        w_addr = r_addr + ADDR_WIDTH'(1);
                    end else if (r_row != c_K_LAST) begin
                        w_col  = '0;
                        w_row  = r_row + c_IDX_W'(1);
                        w_addr = r_addr + c_ROW_STEP;
                    end else begin
                        w_addr_vld = 1'b0;
                        w_cnt      = r_cnt + c_CNT_W'(1);
                        w_state    = (r_cnt == c_ANCHOR_LAST) ? c_S_DONE : c_S_IDLE;
                    end
                end
            end
            c_S_DONE: begin
                w_cnt   = '0;
                w_state = c_S_IDLE;
            end
            default: w_state = c_S_IDLE;
        endcase

        // Dropping enable abandons any window and returns to the reset picture.
        if (!enable) begin
            w_state    = c_S_IDLE;
            w_addr     = '0;
            w_addr_vld = 1'b0;
            w_row      = '0;
            w_col      = '0;
            w_cnt      = '0;
            w_h        = '0;
            w_w        = '0;
        end

        // Generator may only advance while we sit in IDLE waiting for it.
        w_anchor_pause = !(w_anchor_en && (w_state == c_S_IDLE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_S_IDLE;
            r_anchor_en    <= 1'b0;
            r_anchor_pause <= 1'b1;
            r_addr         <= '0;
            r_addr_vld     <= 1'b0;
            r_row          <= '0;
            r_col          <= '0;
            r_cnt          <= '0;
            r_h            <= '0;
            r_w            <= '0;
        end else begin
            r_state        <= w_state;
            r_anchor_en    <= w_anchor_en;
            r_anchor_pause <= w_anchor_pause;
            r_addr         <= w_addr;
            r_addr_vld     <= w_addr_vld;
            r_row          <= w_row;
            r_col          <= w_col;
            r_cnt          <= w_cnt;
            r_h            <= w_h;
            r_w            <= w_w;
        end
    end

    assign anchor_en    = r_anchor_en;
    assign anchor_pause = r_anchor_pause;
    assign addr         = r_addr;
    assign addr_vld     = r_addr_vld;
    assign win_last     = r_addr_vld && (r_row == c_K_LAST) && (r_col == c_K_LAST);
    assign frame_done   = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_addr_gen
// Description : Directed self-checking bench for conv_window_addr_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_main = 1'b0;
    logic        en_ofs = 1'b0;
    logic        en_k1 = 1'b0;
    logic        addr_rdy = 1'b0;
    logic [31:0] gen_h = '0;
    logic [31:0] gen_w = '0;
    logic [31:0] ofs_h = 32'd2;
    logic [31:0] ofs_w = 32'd5;
    logic [31:0] k1_h = 32'd1;
    logic [31:0] k1_w = 32'd2;

    logic        main_anchor_en, main_anchor_pause, main_vld, main_last, main_frame_done;
    logic [15:0] main_addr;
    logic        ofs_anchor_en, ofs_anchor_pause, ofs_vld, ofs_last, ofs_frame_done;
    logic [15:0] ofs_addr;
    logic        k1_anchor_en, k1_anchor_pause, k1_vld, k1_last, k1_frame_done;
    logic [15:0] k1_addr;

    int n_cmp = 0;
    int n_err = 0;
    int gen_adv = 0;
    int fd_count = 0;
    int cyc_g = 0;
    int sel = 0;
    int first_c = 0;
    int span_c = 0;
    int t_last = 0;
    int t_prev = 0;

    logic [15:0] s_addr;
    logic        s_vld, s_last;

    always #5 clk = ~clk;

    conv_window_addr_gen dut (
        .clk(clk), .rst(rst), .enable(en_main),
        .anchor_en(main_anchor_en), .anchor_pause(main_anchor_pause),
        .anchor_height(gen_h), .anchor_width(gen_w),
        .addr(main_addr), .addr_vld(main_vld), .addr_rdy(addr_rdy),
        .win_last(main_last), .frame_done(main_frame_done)
    );

    conv_window_addr_gen #(.BASE_ADDR(32'h100)) dut_ofs (
        .clk(clk), .rst(rst), .enable(en_ofs),
        .anchor_en(ofs_anchor_en), .anchor_pause(ofs_anchor_pause),
        .anchor_height(ofs_h), .anchor_width(ofs_w),
        .addr(ofs_addr), .addr_vld(ofs_vld), .addr_rdy(addr_rdy),
        .win_last(ofs_last), .frame_done(ofs_frame_done)
    );

    conv_window_addr_gen #(.KERNEL_SIZE(1)) dut_k1 (
        .clk(clk), .rst(rst), .enable(en_k1),
        .anchor_en(k1_anchor_en), .anchor_pause(k1_anchor_pause),
        .anchor_height(k1_h), .anchor_width(k1_w),
        .addr(k1_addr), .addr_vld(k1_vld), .addr_rdy(addr_rdy),
        .win_last(k1_last), .frame_done(k1_frame_done)
    );

    always_comb begin
        s_addr = main_addr;
        s_vld  = main_vld;
        s_last = main_last;
        if (sel == 1) begin
            s_addr = ofs_addr;
            s_vld  = ofs_vld;
            s_last = ofs_last;
        end else if (sel == 2) begin
            s_addr = k1_addr;
            s_vld  = k1_vld;
            s_last = k1_last;
        end
    end

    // 30x30 anchor generator model, step 1.
    always @(posedge clk) begin
        cyc_g <= cyc_g + 1;
        if (main_frame_done) fd_count <= fd_count + 1;
        if (rst || !main_anchor_en) begin
            gen_h <= '0;
            gen_w <= '0;
        end else if (!main_anchor_pause) begin
            gen_adv <= gen_adv + 1;
            if (gen_w == 32'd29) begin
                gen_w <= '0;
                gen_h <= (gen_h == 32'd29) ? 32'd0 : gen_h + 32'd1;
            end else begin
                gen_w <= gen_w + 32'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collects n_stop handshakes of one window and checks each address.
    task automatic collect(input int s, input int k, input int base, input int h,
                           input int w, input bit bp, input int n_stop);
        int          idx = 0;
        int          cyc = 0;
        int          ex;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [15:0] pa = '0;
        sel     = s;
        first_c = -1;
        while (idx < n_stop && cyc < 400) begin
            @(negedge clk);
            addr_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr) begin
                chk("hold_vld", 32'(s_vld), 32'd1);
                chk("hold_addr", 32'(s_addr), 32'(pa));
            end
            if (s_vld && addr_rdy) begin
                ex = base + (h + idx / k) * 32 + w + idx % k;
                chk("addr", 32'(s_addr), ex & 32'hFFFF);
                chk("win_last", 32'(s_last), 32'(idx == k * k - 1));
                if (first_c < 0) first_c = cyc;
                span_c = cyc - first_c + 1;
                t_last = cyc_g;
                idx++;
            end
            pv = s_vld;
            pr = addr_rdy;
            pa = s_addr;
            cyc++;
        end
        if (idx < n_stop) chk("window_timeout", idx, n_stop);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_anchor_en"}, 32'(main_anchor_en), 32'd0);
        chk({tag, "_pause"}, 32'(main_anchor_pause), 32'd1);
        chk({tag, "_addr"}, 32'(main_addr), 32'd0);
        chk({tag, "_vld"}, 32'(main_vld), 32'd0);
        chk({tag, "_win_last"}, 32'(main_last), 32'd0);
        chk({tag, "_frame_done"}, 32'(main_frame_done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");

        rst     = 1'b0;
        en_main = 1'b1;
        @(negedge clk);
        chk("en_anchor_en", 32'(main_anchor_en), 32'd1);
        chk("en_pause", 32'(main_anchor_pause), 32'd0);
        chk("en_vld", 32'(main_vld), 32'd0);
        @(negedge clk);
        chk("acc_pause", 32'(main_anchor_pause), 32'd1);
        chk("acc_vld", 32'(main_vld), 32'd0);
        chk("acc_gen_adv", gen_adv, 1);

        // Full frame: window 1 under backpressure, window 900 closes the frame.
        for (int i = 0; i < 901; i++) begin
            collect(0, 3, 0, (i % 900) / 30, i % 30, (i == 1), 9);
            if (i == 0) begin
                chk("first_vld_latency", first_c, 0);
                chk("span_rdy1", span_c, 9);
            end
            if (i == 3) t_prev = t_last;
            if (i == 4) chk("win_period", t_last - t_prev, 11);
            @(negedge clk);
            chk("gen_adv", gen_adv, i + 1);
            chk("frame_done", 32'(main_frame_done), 32'(i == 899));
            if (i == 899) chk("done_pause", 32'(main_anchor_pause), 32'd1);
        end
        chk("fd_count", fd_count, 1);

        // Enable drop after the 4th handshake of anchor (0,1).
        collect(0, 3, 0, 0, 1, 1'b0, 4);
        @(negedge clk);
        en_main = 1'b0;
        @(negedge clk);
        chk_reset_outs("endrop");
        repeat (2) @(negedge clk);
        en_main = 1'b1;
        collect(0, 3, 0, 0, 0, 1'b0, 9);
        @(negedge clk);

        // Reset in the middle of a walk.
        collect(0, 3, 0, 0, 1, 1'b0, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs("rstwalk");
        chk("rstwalk_fd_count", fd_count, 1);
        rst     = 1'b0;
        en_main = 1'b0;

        // Non-zero base with anchor (2,5).
        en_ofs = 1'b1;
        collect(1, 3, 32'h100, 2, 5, 1'b0, 9);
        en_ofs = 1'b0;

        // K=1: single-address windows every 3 cycles.
        en_k1 = 1'b1;
        collect(2, 1, 0, 1, 2, 1'b0, 1);
        t_prev = t_last;
        collect(2, 1, 0, 1, 2, 1'b0, 1);
        chk("k1_period", t_last - t_prev, 3);
        en_k1 = 1'b0;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
